// File: rtl/aes_dec_iter_ctrl_pkg.sv
// Shared definitions for the iterative AES decrypt path: FSM encoding, round
// counts per key size, default key-index width and GF(2^8) helpers.
package aes_dec_iter_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROUND = 2'd1,
        S_FINAL = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam int NR_AES128   = 10;
    localparam int NR_AES192   = 12;
    localparam int NR_AES256   = 14;
    localparam int RKW_DEFAULT = 4;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Inverse affine map followed by the field inverse (x^254, with 0 -> 0).
    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        logic [7:0] b;
        logic [7:0] sq;
        logic [7:0] r;
        b  = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
        sq = b;
        r  = 8'h01;
        for (int i = 0; i < 7; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

endpackage

// File: rtl/aes_dec_round.sv
// Combinational AES inverse round: InvShiftRows -> InvSubBytes -> AddRoundKey
// -> InvMixColumns, with last_round skipping InvMixColumns. Byte 0 is [127:120].
module aes_dec_round
    import aes_dec_iter_ctrl_pkg::*;
(
    input  logic [127:0] state,
    input  logic [127:0] rk,
    input  logic         last_round,
    output logic [127:0] result
);

    logic [127:0] sb;
    logic [127:0] ark;
    logic [127:0] mc;

    // Byte i sits at row i%4, column i/4; row r rotates right by r.
    for (genvar i = 0; i < 16; i++) begin : g_byte
        localparam int R   = i % 4;
        localparam int SRC = R + 4 * (((i / 4) - R + 4) % 4);
        assign sb[127-8*i -: 8] = inv_sbox(state[127-8*SRC -: 8]);
    end

    assign ark = sb ^ rk;

    for (genvar c = 0; c < 4; c++) begin : g_col
        logic [7:0] a0, a1, a2, a3;
        assign a0 = ark[127-32*c    -: 8];
        assign a1 = ark[127-32*c-8  -: 8];
        assign a2 = ark[127-32*c-16 -: 8];
        assign a3 = ark[127-32*c-24 -: 8];
        assign mc[127-32*c -: 32] = {
            gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
            gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
            gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
            gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)
        };
    end

    assign result = last_round ? ark : mc;

endmodule

// File: rtl/aes_dec_iter_ctrl.sv
// Iterative AES inverse-cipher sequencer, one inverse round per clock.
// Define AES_DEC_CLEAR_EN to scrub the plaintext register after each handoff.
module aes_dec_iter_ctrl
    import aes_dec_iter_ctrl_pkg::*;
#(
    parameter int NR  = NR_AES128,
    parameter int RKW = RKW_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [127:0]   in_data,
    output logic [RKW-1:0] rk_idx,
    input  logic [127:0]   rk_in,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [127:0]   out_data,
    output logic           busy
);

    state_t         state, state_nxt;
    logic [RKW-1:0] cnt, cnt_nxt;
    logic [127:0]   data, data_nxt, round_out;
    logic           last_round;
    logic           out_valid_q, busy_q;

    aes_dec_round u_round (
        .state      (data),
        .rk         (rk_in),
        .last_round (last_round),
        .result     (round_out)
    );

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        data_nxt   = data;
        rk_idx     = RKW'(NR);
        last_round = 1'b0;
        case (state)
            S_IDLE: begin
                if (in_valid) begin
                    data_nxt  = in_data ^ rk_in;
                    cnt_nxt   = RKW'(NR - 1);
                    state_nxt = S_ROUND;
                end
            end
            S_ROUND: begin
                rk_idx   = cnt;
                data_nxt = round_out;
                if (cnt == RKW'(1)) state_nxt = S_FINAL;
                else                cnt_nxt   = cnt - RKW'(1);
            end
            S_FINAL: begin
                rk_idx     = '0;
                last_round = 1'b1;
                data_nxt   = round_out;
                state_nxt  = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    state_nxt = S_IDLE;
`ifdef AES_DEC_CLEAR_EN
                    data_nxt  = '0;
`endif
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Flags are flopped from the next state so they come straight off registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= RKW'(NR - 1);
            data        <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            data        <= data_nxt;
            out_valid_q <= (state_nxt == S_DONE);
            busy_q      <= (state_nxt != S_IDLE);
        end
    end

    assign in_ready  = (state == S_IDLE);
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
`ifdef AES_DEC_CLEAR_EN
    assign out_data  = out_valid_q ? data : '0;
`else
    assign out_data  = data;
`endif

endmodule
